// File: rtl/dht_ascii_fmt_if.sv
// dht_ascii_fmt_if: request/result bundle between sensor scaling logic and the ASCII formatter
//   start     : one-cycle conversion request
//   bin_in    : CH_NUM unsigned values, channel c at [c*BIN_W +: BIN_W]
//   sign_in   : per-channel negative flag
//   busy      : conversion in progress
//   done      : one-cycle pulse when ascii_out/ovf/sign_out have just updated
//   ascii_out : channel c digit d (d=0 units) at [(c*DIGITS+d)*8 +: 8]
//   sign_out  : sign flags captured with the request
//   ovf       : per-channel value >= 10^DIGITS
interface dht_ascii_fmt_if #(
  parameter int CH_NUM = 2,
  parameter int BIN_W  = 17,
  parameter int DIGITS = 6
);
  logic                       start;
  logic [CH_NUM*BIN_W-1:0]    bin_in;
  logic [CH_NUM-1:0]          sign_in;
  logic                       busy;
  logic                       done;
  logic [CH_NUM*DIGITS*8-1:0] ascii_out;
  logic [CH_NUM-1:0]          sign_out;
  logic [CH_NUM-1:0]          ovf;
  modport master (output start, bin_in, sign_in, input busy, done, ascii_out, sign_out, ovf);
  modport slave (input start, bin_in, sign_in, output busy, done, ascii_out, sign_out, ovf);
endinterface

// File: rtl/dht_ascii_fmt.sv
// dht_ascii_fmt: multi-channel binary-to-ASCII formatter using one shared double-dabble engine
//   sys_clk   : rising-edge clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : dht_ascii_fmt_if slave (start/bin_in/sign_in in, busy/done/ascii_out/sign_out/ovf out)
module dht_ascii_fmt #(
  parameter int CH_NUM   = 2,
  parameter int BIN_W    = 17,
  parameter int DIGITS   = 6,
  parameter bit BLANK_LZ = 1'b0
) (
  input logic         sys_clk,
  input logic         sys_rst_n,
  dht_ascii_fmt_if.slave bus
);
  localparam int CH_W  = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = BIN_W > 1 ? $clog2(BIN_W) : 1;
  localparam int BCD_W = DIGITS * 4;
  localparam int CHB_W = DIGITS * 8;
  localparam int OUT_W = CH_NUM * CHB_W;
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  localparam logic [63:0] P10 = pow10(DIGITS);
  // When 10^DIGITS does not fit in BIN_W+1 bits no input can reach it, so all-ones is a safe unreachable limit
  localparam logic [BIN_W:0] OVF_LIM = (P10 >> (BIN_W + 1)) != 64'd0 ? {(BIN_W+1){1'b1}} : P10[BIN_W:0];
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;
  state_t state, nxt;
  logic [CH_NUM*BIN_W-1:0] snap_bin;
  logic [CH_NUM-1:0]       snap_sign;
  logic [CH_W-1:0]         ch;
  logic [BIN_W-1:0]        sr;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        cnt;
  logic [CH_NUM-1:0]       ovf_sh;
  logic [OUT_W-1:0]        shadow;
  logic [OUT_W-1:0]        shadow_d;
  logic [CHB_W-1:0]        store_bytes;
  logic                    lead;
  logic                    last;
  assign last = ch == CH_W'(CH_NUM - 1);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = cnt == CNT_W'(BIN_W - 1) ? STORE : SHIFT;
      STORE:   nxt = last ? DONE : LOAD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // add-3 correction applied to every nibble before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end
  // walk from the top digit down; lead stays set while every digit seen so far is zero (units never blanked)
  always_comb begin
    store_bytes = '0;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lead = lead && bcd[d*4 +: 4] == 4'd0 && d != 0;
      store_bytes[d*8 +: 8] = ovf_sh[ch] ? 8'h39 : (BLANK_LZ && lead) ? 8'h20 : {4'h3, bcd[d*4 +: 4]};
    end
  end
  always_comb begin
    shadow_d = shadow;
    if (state == STORE) shadow_d[ch*CHB_W +: CHB_W] = store_bytes;
  end
  // outputs load on the edge into DONE so they become visible in the same cycle as the done pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      snap_bin      <= '0;
      snap_sign     <= '0;
      ch            <= '0;
      sr            <= '0;
      bcd           <= '0;
      cnt           <= '0;
      ovf_sh        <= '0;
      shadow        <= '0;
      bus.ascii_out <= {(CH_NUM*DIGITS){8'h30}};
      bus.sign_out  <= '0;
      bus.ovf       <= '0;
    end else begin
      shadow <= shadow_d;
      if (state == IDLE && bus.start) begin
        snap_bin  <= bus.bin_in;
        snap_sign <= bus.sign_in;
        ch        <= '0;
      end
      if (state == LOAD) begin
        sr         <= snap_bin[ch*BIN_W +: BIN_W];
        bcd        <= '0;
        cnt        <= '0;
        ovf_sh[ch] <= {1'b0, snap_bin[ch*BIN_W +: BIN_W]} >= OVF_LIM;
      end
      if (state == SHIFT) begin
        {bcd, sr} <= {bcd_adj[BCD_W-2:0], sr, 1'b0};
        cnt       <= cnt + 1'b1;
      end
      if (state == STORE && !last) ch <= ch + 1'b1;
      if (state == STORE && last) begin
        bus.ascii_out <= shadow_d;
        bus.ovf       <= ovf_sh;
        bus.sign_out  <= snap_sign;
      end
    end
endmodule

// File: tb/tb_dht_ascii_fmt.sv
// tb_dht_ascii_fmt: randomized self-checking bench for three formatter configurations against a decimal model
module tb_dht_ascii_fmt;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;
  dht_ascii_fmt_if #(.CH_NUM(2), .BIN_W(17), .DIGITS(6)) if0 ();
  dht_ascii_fmt_if #(.CH_NUM(2), .BIN_W(20), .DIGITS(6)) if1 ();
  dht_ascii_fmt_if #(.CH_NUM(2), .BIN_W(17), .DIGITS(6)) if2 ();
  dht_ascii_fmt dut0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if0));
  dht_ascii_fmt #(.BIN_W(20)) dut1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if1));
  dht_ascii_fmt #(.BLANK_LZ(1'b1)) dut2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if2));
  logic [95:0] asc [3];
  logic [1:0]  ov [3];
  logic [1:0]  sg [3];
  logic        bz [3];
  logic        dn [3];
  assign asc[0] = if0.ascii_out;
  assign asc[1] = if1.ascii_out;
  assign asc[2] = if2.ascii_out;
  assign ov[0] = if0.ovf;
  assign ov[1] = if1.ovf;
  assign ov[2] = if2.ovf;
  assign sg[0] = if0.sign_out;
  assign sg[1] = if1.sign_out;
  assign sg[2] = if2.sign_out;
  assign bz[0] = if0.busy;
  assign bz[1] = if1.busy;
  assign bz[2] = if2.busy;
  assign dn[0] = if0.done;
  assign dn[1] = if1.done;
  assign dn[2] = if2.done;
  int n_chk = 0;
  int n_fail = 0;
  longint val [3][2];
  logic [1:0] sgn [3];
  int dc [3];
  int dl [3];
  int nd [3];
  bit bh [0:127];
  function automatic logic [47:0] model(input longint v, input bit blank);
    logic [47:0] r;
    longint x;
    x = v;
    if (v >= 1000000) return {6{8'h39}};
    for (int d = 0; d < 6; d++) begin
      r[d*8 +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    if (blank)
      for (int d = 5; d > 0; d--)
        if (r[d*8 +: 8] == 8'h30) r[d*8 +: 8] = 8'h20;
        else break;
    return r;
  endfunction
  task automatic set_vals(input longint a0, a1, b0, b1, c0, c1, input logic [1:0] s);
    val[0][0] = a0; val[0][1] = a1;
    val[1][0] = b0; val[1][1] = b1;
    val[2][0] = c0; val[2][1] = c1;
    for (int k = 0; k < 3; k++) sgn[k] = s;
  endtask
  task automatic apply();
    if0.bin_in = {17'(val[0][1]), 17'(val[0][0])};
    if1.bin_in = {20'(val[1][1]), 20'(val[1][0])};
    if2.bin_in = {17'(val[2][1]), 17'(val[2][0])};
    if0.sign_in = sgn[0];
    if1.sign_in = sgn[1];
    if2.sign_in = sgn[2];
  endtask
  task automatic set_start(input logic s);
    if0.start = s;
    if1.start = s;
    if2.start = s;
  endtask
  // start is held high during cycle 0 (accepted at edge 0); extra start pulses occupy cycles s1/s2/s3
  task automatic go(input int budget, input int s1, input int s2, input int s3, input int chg_at);
    apply();
    @(negedge sys_clk);
    set_start(1'b1);
    for (int k = 0; k < 3; k++) begin dc[k] = -1; dl[k] = -1; nd[k] = 0; end
    for (int c = 1; c <= budget; c++) begin
      @(negedge sys_clk);
      bh[c] = bz[0];
      for (int k = 0; k < 3; k++)
        if (dn[k]) begin
          nd[k]++;
          if (dc[k] < 0) dc[k] = c;
          dl[k] = c;
        end
      set_start(c == s1 || c == s2 || c == s3);
      if (c == chg_at) begin
        if0.bin_in = 34'({$urandom(), $urandom()});
        if1.bin_in = 40'({$urandom(), $urandom()});
        if2.bin_in = 34'({$urandom(), $urandom()});
        if0.sign_in = ~sgn[0];
        if1.sign_in = ~sgn[1];
        if2.sign_in = ~sgn[2];
      end
    end
    set_start(1'b0);
  endtask
  task automatic test_reset();
    set_start(1'b0);
    set_vals(0, 0, 0, 0, 0, 0, 2'b00);
    apply();
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (asc[k] !== {12{8'h30}}) begin n_fail++; $display("FAIL reset_ascii dut%0d: got %h want %h", k, asc[k], {12{8'h30}}); end
      n_chk++;
      if ({bz[k], dn[k], ov[k], sg[k]} !== 6'b0) begin n_fail++; $display("FAIL reset_flags dut%0d: busy/done/ovf/sign got %b want 000000", k, {bz[k], dn[k], ov[k], sg[k]}); end
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_chk++;
    if (asc[2] !== {12{8'h30}} || bz[0] !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: ascii %h busy %b want all 30 and 0", asc[2], bz[0]); end
  endtask
  task automatic test_basic();
    int e;
    set_vals(2550, 6500, 2550, 6500, 2550, 6500, 2'b01);
    go(50, 0, 0, 0, 0);
    n_chk++;
    if (dc[0] != 39 || nd[0] != 1) begin n_fail++; $display("FAIL latency17: done at %0d count %0d want 39 and 1", dc[0], nd[0]); end
    n_chk++;
    if (dc[1] != 45) begin n_fail++; $display("FAIL latency20: done at %0d want 45", dc[1]); end
    n_chk++;
    if (dc[2] != 39) begin n_fail++; $display("FAIL latency_blank: done at %0d want 39", dc[2]); end
    e = 0;
    for (int c = 1; c <= 50; c++) if (bh[c] !== (c <= 39)) e++;
    n_chk++;
    if (e != 0) begin n_fail++; $display("FAIL busy_window: %0d cycles wrong want 0", e); end
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (asc[k][c*48 +: 48] !== model(val[k][c], k == 2)) begin n_fail++; $display("FAIL basic_ascii dut%0d ch%0d: got %h want %h", k, c, asc[k][c*48 +: 48], model(val[k][c], k == 2)); end
      end
      n_chk++;
      if (ov[k] !== 2'b00 || sg[k] !== 2'b01) begin n_fail++; $display("FAIL basic_flags dut%0d: ovf %b sign %b want 00 01", k, ov[k], sg[k]); end
    end
  endtask
  task automatic test_boundary();
    longint v;
    for (int r = 0; r < 2; r++) begin
      v = r == 0 ? 0 : 131071;
      set_vals(v, v, v, v, v, v, r == 0 ? 2'b10 : 2'b11);
      go(50, 0, 0, 0, 10);
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 2; c++) begin
          n_chk++;
          if (asc[k][c*48 +: 48] !== model(val[k][c], k == 2)) begin n_fail++; $display("FAIL boundary_ascii v=%0d dut%0d ch%0d: got %h want %h", v, k, c, asc[k][c*48 +: 48], model(val[k][c], k == 2)); end
        end
        n_chk++;
        if (ov[k] !== 2'b00 || sg[k] !== sgn[k]) begin n_fail++; $display("FAIL boundary_flags dut%0d: ovf %b sign %b want 00 %b", k, ov[k], sg[k], sgn[k]); end
      end
    end
  endtask
  task automatic test_wide();
    set_vals(131071, 99999, 999999, 1000000, 7, 130000, 2'b10);
    go(50, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (asc[1][c*48 +: 48] !== model(val[1][c], 1'b0)) begin n_fail++; $display("FAIL wide_ascii ch%0d: got %h want %h", c, asc[1][c*48 +: 48], model(val[1][c], 1'b0)); end
    end
    n_chk++;
    if (ov[1] !== 2'b10) begin n_fail++; $display("FAIL wide_ovf: got %b want 10", ov[1]); end
  endtask
  task automatic test_blank();
    set_vals(0, 305, 0, 305, 0, 305, 2'b00);
    go(50, 0, 0, 0, 0);
    n_chk++;
    if (asc[2] !== {"   305", "     0"}) begin n_fail++; $display("FAIL blank_ascii: got %h want %h", asc[2], {"   305", "     0"}); end
    n_chk++;
    if (asc[0] !== {"000305", "000000"}) begin n_fail++; $display("FAIL noblank_ascii: got %h want %h", asc[0], {"000305", "000000"}); end
  endtask
  task automatic test_back_to_back();
    set_vals(4321, 98765, 1000001, 54321, 40, 1, 2'b11);
    go(100, 5, 39, 40, 0);
    n_chk++;
    if (dc[0] != 39 || dl[0] != 79 || nd[0] != 2) begin n_fail++; $display("FAIL b2b_done: first %0d last %0d count %0d want 39 79 2", dc[0], dl[0], nd[0]); end
    n_chk++;
    if (asc[0] !== model(val[0][0], 1'b0) + (96'(model(val[0][1], 1'b0)) << 48)) begin n_fail++; $display("FAIL b2b_ascii: got %h", asc[0]); end
    n_chk++;
    if (ov[1] !== 2'b01 || sg[0] !== 2'b11) begin n_fail++; $display("FAIL b2b_flags: ovf1 %b sign0 %b want 01 11", ov[1], sg[0]); end
  endtask
  task automatic test_reset_mid();
    int n;
    set_vals(77777, 12, 999999, 1000000, 5, 60000, 2'b01);
    apply();
    @(negedge sys_clk);
    set_start(1'b1);
    @(negedge sys_clk);
    set_start(1'b0);
    repeat (19) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if (bz[0] !== 1'b0 || dn[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: busy %b done %b want 0 0", bz[0], dn[0]); end
    n_chk++;
    if (asc[0] !== {12{8'h30}} || asc[2] !== {12{8'h30}}) begin n_fail++; $display("FAIL midrst_ascii: got %h / %h want all 30", asc[0], asc[2]); end
    n_chk++;
    if (ov[1] !== 2'b00 || sg[0] !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: ovf1 %b sign0 %b want 00 00", ov[1], sg[0]); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (dn[0] || dn[1]) n++;
    end
    n_chk++;
    if (n != 0 || asc[0] !== {12{8'h30}}) begin n_fail++; $display("FAIL midrst_nopublish: dones %0d ascii %h want 0 and all 30", n, asc[0]); end
    go(50, 0, 0, 0, 0);
    n_chk++;
    if (dc[0] != 39 || asc[0] !== {model(val[0][1], 1'b0), model(val[0][0], 1'b0)}) begin n_fail++; $display("FAIL midrst_recover: done %0d ascii %h want 39", dc[0], asc[0]); end
    n_chk++;
    if (ov[1] !== 2'b10 || sg[1] !== 2'b01) begin n_fail++; $display("FAIL midrst_recover_flags: ovf %b sign %b want 10 01", ov[1], sg[1]); end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < 2; c++) begin
        val[0][c] = $urandom_range(131071, 0);
        val[1][c] = ($urandom() % 2) ? $urandom_range(1000010, 999990) : $urandom_range(1048575, 0);
        val[2][c] = ($urandom() % 2) ? $urandom_range(999, 0) : $urandom_range(131071, 0);
      end
      for (int k = 0; k < 3; k++) sgn[k] = 2'($urandom());
      go(50, 0, 0, 0, 3 + it);
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 2; c++) begin
          n_chk++;
          if (asc[k][c*48 +: 48] !== model(val[k][c], k == 2)) begin n_fail++; $display("FAIL rand_ascii it%0d dut%0d ch%0d v=%0d: got %h want %h", it, k, c, val[k][c], asc[k][c*48 +: 48], model(val[k][c], k == 2)); end
        end
        n_chk++;
        if (ov[k] !== {val[k][1] >= 1000000, val[k][0] >= 1000000} || sg[k] !== sgn[k]) begin n_fail++; $display("FAIL rand_flags it%0d dut%0d: ovf %b sign %b want %b %b", it, k, ov[k], sg[k], {val[k][1] >= 1000000, val[k][0] >= 1000000}, sgn[k]); end
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_wide();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dht_ascii_fmt.md
Name: dht_ascii_fmt

Overview:
- Multi-channel, parametrised binary-to-ASCII formatter for sensor readouts, e.g. DHT11 temperature ×100 and humidity ×100.
- Sits between the sensor decode/scaling logic and the UART/OLED text path.
- Replaces wide combinational divide/modulo with a sequential shift-add-3 (double-dabble) engine shared across channels.
- Adds a start/busy/done handshake, an atomic output update, an overflow flag, optional leading-zero blanking and sign pass-through.

Parameters:
- CH_NUM, 2, number of channels converted per request.
- BIN_W, 17, width of each unsigned binary input value.
- DIGITS, 6, decimal digits (ASCII bytes) produced per channel.
- BLANK_LZ, 0, 1 = replace leading zeros with 0x20 (space); digit 0 is never blanked.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- bin_in  in  CH_NUM*BIN_W  channel c occupies [c*BIN_W +: BIN_W].
- sign_in  in  CH_NUM  per-channel negative flag, passed through.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when new results are visible.
- ascii_out  out  CH_NUM*DIGITS*8  channel c, digit d (d=0 is the units digit) at [(c*DIGITS+d)*8 +: 8].
- sign_out  out  CH_NUM  registered copy of sign_in, captured at start.
- ovf  out  CH_NUM  set when the channel value is ≥ 10^DIGITS.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; busy = 0, done = 0, sign_out = 0, ovf = 0.
  - Every ascii_out byte = 0x30 ('0'), regardless of BLANK_LZ.
  - Working registers cleared.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE:
  - start = 1 snapshots bin_in and sign_in into internal registers; channel index ch = 0; next state LOAD.
  - Later input changes do not affect the conversion in flight.
- LOAD (1 cycle):
  - shift register = snapshot[ch]; BCD register (DIGITS*4 bits) = 0; bit counter = 0.
  - ovf_shadow[ch] = (value ≥ 10^DIGITS), compared against a constant of width BIN_W+1.
- SHIFT (BIN_W cycles, one per cycle):
  - Every BCD nibble ≥ 5 gets +3.
  - Then {BCD, shift reg} shifts left by 1, MSB-first.
  - After BIN_W shifts, go to STORE.
- STORE (1 cycle):
  - Writes DIGITS ASCII bytes for channel ch into the shadow buffer: byte = 0x30 + nibble.
  - If ovf_shadow[ch], all bytes = 0x39 ('9'), i.e. saturate.
  - If BLANK_LZ = 1 and no overflow: every digit above the most significant non-zero digit becomes 0x20; a value of 0 gives "     0".
  - If ch = CH_NUM-1, go to DONE; otherwise ch++ and go to LOAD.
- DONE (1 cycle):
  - Shadow buffer, ovf_shadow and the sign snapshot are copied to ascii_out, ovf and sign_out together, so all channels update atomically.
  - done = 1 for this single cycle; next state IDLE.
- busy = 1 in LOAD, SHIFT, STORE and DONE; 0 in IDLE.
- Latency: start accepted at edge 0; done and the new outputs are high/visible in cycle CH_NUM*(BIN_W+2)+1. With defaults this is cycle 39.
- start while busy = 1 is ignored; it is not queued.
- start can be accepted in the cycle immediately after done.
- Outputs hold their last values between conversions.
- Reset mid-conversion aborts the conversion. Outputs return to their reset values; partial results are never published.
- Digits beyond what BIN_W can represent simply stay '0'.

Test Plan:
- Defaults; bin_in ch0 = 2550, ch1 = 6500, sign_in = 2'b01; pulse start → done in cycle 39, busy high in cycles 1–39, ch0 = "002550" (ascii_out[47:0] = 0x30,0x30,0x32,0x35,0x35,0x30 from MSB digit), ch1 = "006500", sign_out = 2'b01, ovf = 0.
- Boundary values 0 and 131071 on both channels → "000000" and "131071"; then change bin_in during busy → published result still reflects the start-time snapshot.
- BIN_W = 20, DIGITS = 6; ch0 = 999999, ch1 = 1000000 → ch0 = "999999", ovf = 2'b10, ch1 = "999999" (saturated).
- BLANK_LZ = 1; ch0 = 0, ch1 = 305 → ch0 = "     0", ch1 = "   305".
- start pulsed again at cycles 5 and 39 of a conversion → both ignored, exactly one done; start at cycle 40 (after done) → accepted, second done at cycle 79.
- Assert sys_rst_n low at cycle 20 of a conversion → immediately busy = 0, ascii_out = all 0x30, ovf = 0, no done pulse; the next start converts normally.
